ray_scan_controller: RTL and testbench
======================================

Name: ray_scan_controller

Overview:
Frame-level sequencer for generate_ray. On a start pulse it walks every pixel in raster order and issues SPP jittered samples per pixel. It drives generate_ray's pixel_x/pixel_y/stall inputs and converts downstream backpressure into that stall. It also tracks the generator's 2-cycle pipeline so each generated ray leaves with a valid flag and its pixel/sample tag.

Parameters:
H_RES, 800, horizontal pixel count; pixel_x range [0, H_RES-1]
V_RES, 600, vertical pixel count; pixel_y range [0, V_RES-1]
SPP, 4, samples per pixel (>=1)
GEN_LATENCY, 2, generate_ray latency in non-stalled cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle frame start request
abort  in  1  synchronous frame abort
ray_ready  in  1  downstream accepts the ray this cycle
pixel_x  out  10  pixel column to generate_ray
pixel_y  out  10  pixel row to generate_ray
gen_stall  out  1  to generate_ray stall
ray_valid  out  1  generate_ray output is a live sample this cycle
tag_x  out  10  pixel column of the ray at generate_ray output
tag_y  out  10  pixel row of the ray at generate_ray output
tag_sample  out  8  sample index within the pixel, [0, SPP-1]
tag_last  out  1  ray is the final sample of the frame
busy  out  1  high in SCAN and DRAIN
frame_done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- One clock (clk) with a synchronous, active-high reset (rst). Reset zeroes all outputs and registers, clears the valid pipe and sets state IDLE. Reset and abort dominate every other input in the same cycle.
- gen_stall = ray_valid & ~ray_ready, combinational.
  - An "advance" cycle is any cycle with gen_stall low.
  - The counters, the tag/valid pipe and generate_ray all move only on advance cycles.
  - With gen_stall high, ray_valid and all tags hold stable.
- Handshake: a ray is transferred on a cycle where ray_valid & ray_ready. Bubbles (ray_valid=0) never stall the pipeline.
- Issue counters: sample s, x, y.
  - On each advance in SCAN, s increments.
  - At s=SPP-1, s wraps to 0 and x increments.
  - At x=H_RES-1, x wraps to 0 and y increments.
  - pixel_x = x and pixel_y = y, registered.
- Tag pipe: GEN_LATENCY stages of {valid, x, y, s, last}. Stage 0 is loaded from the current issue (valid=1 in SCAN, 0 otherwise). The tail drives ray_valid and the tag_* outputs, so they align with generated_ray.
- FSM states and transitions:
  - IDLE: busy=0. Counters are held at 0. start -> SCAN.
  - SCAN: one sample enters the pipe per advance. The advance that issues (H_RES-1, V_RES-1, SPP-1) marks that entry last=1 and moves to DRAIN.
  - DRAIN: bubbles are issued. When the entry with last=1 transfers (ray_valid & ray_ready & tag_last), go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. busy=0.
- start is ignored in SCAN, DRAIN and DONE; it is not queued.
- abort in SCAN or DRAIN:
  - Next state is IDLE and the pipe valid bits are cleared.
  - Counters return to 0 and frame_done is not pulsed.
  - Rays already in flight are discarded, including a stalled ray_valid.
- Total transfers per frame = H_RES*V_RES*SPP, with no duplicates or skips, regardless of the ray_ready pattern.
- With ray_ready tied high, the first ray_valid appears GEN_LATENCY cycles after the first SCAN cycle. frame_done fires H_RES*V_RES*SPP + GEN_LATENCY + 1 cycles after SCAN entry.
- Counter widths: x and y are 10 bits, and s is 8 bits. SPP of 256 or more is unsupported.

Test Plan:
- H_RES=4, V_RES=3, SPP=2, ray_ready=1, start pulse -> 24 transfers in raster order: (0,0,s0), (0,0,s1), (1,0,s0), ... (3,2,s1). First ray_valid 2 cycles after SCAN entry; tag_last only on (3,2,1); frame_done pulse at cycle 27.
- Same config, ray_ready low for 5 cycles mid-frame while ray_valid=1 -> gen_stall=1 for those 5 cycles. Tags, pixel_x/y and counters are frozen; no sample lost or duplicated; 24 transfers total.
- Random ray_ready (50%) over a full frame -> the transfer sequence equals the ray_ready=1 reference, and frame_done fires once, after the last transfer.
- abort asserted at transfer 10 -> next cycle busy=0, ray_valid=0, no frame_done. A following start gives a full 24-ray frame starting at (0,0,0).
- rst asserted mid-DRAIN with ray_valid=1 and ray_ready=0 -> next cycle all outputs 0, state IDLE. start in the same cycle as rst is ignored.
- start pulsed during SCAN, and start asserted in the DONE cycle -> both ignored; exactly one frame of 24 rays is produced.

Source files
------------

// File: rtl/ray_scan_controller.sv
// Raster-order frame sequencer for generate_ray: issues SPP samples per pixel, tracks the tag/valid pipe.
// Pipe latency GEN_LATENCY advances; downstream backpressure freezes counters and pipe via gen_stall.
module ray_scan_controller #(
    parameter int H_RES       = 800,
    parameter int V_RES       = 600,
    parameter int SPP         = 4,
    parameter int GEN_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ray_ready,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       gen_stall,
    output logic       ray_valid,
    output logic [9:0] tag_x,
    output logic [9:0] tag_y,
    output logic [7:0] tag_sample,
    output logic       tag_last,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);
    localparam logic [7:0] S_MAX = 8'(SPP - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       vld;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] s;
        logic       last;
    } tag_t;

    state_t     state_q;
    tag_t       pipe_q [GEN_LATENCY];
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] s_q, s_d;
    logic       busy_q;
    logic       frame_done_q;
    logic       advance;
    logic       issue_last;
    logic       last_xfer;
    tag_t       issue;

    assign ray_valid  = pipe_q[GEN_LATENCY-1].vld;
    assign tag_x      = pipe_q[GEN_LATENCY-1].x;
    assign tag_y      = pipe_q[GEN_LATENCY-1].y;
    assign tag_sample = pipe_q[GEN_LATENCY-1].s;
    assign tag_last   = pipe_q[GEN_LATENCY-1].last;
    assign gen_stall  = ray_valid & ~ray_ready;
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        advance    = ~gen_stall;
        issue_last = (state_q == SCAN) && (x_q == X_MAX) && (y_q == Y_MAX) && (s_q == S_MAX);
        last_xfer  = ray_valid & ray_ready & tag_last;

        s_d = s_q + 8'd1;
        x_d = x_q;
        y_d = y_q;
        if (s_q == S_MAX) begin
            s_d = '0;
            x_d = x_q + 10'd1;
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + 10'd1;
            end
        end
        // Counters park at zero once the final sample has been issued.
        if (issue_last) begin
            x_d = '0;
            y_d = '0;
            s_d = '0;
        end

        issue.vld  = (state_q == SCAN);
        issue.x    = x_q;
        issue.y    = y_q;
        issue.s    = s_q;
        issue.last = issue_last;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            s_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < GEN_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            if (advance) begin
                pipe_q[0] <= issue;
                for (int i = 1; i < GEN_LATENCY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            case (state_q)
                IDLE: begin
                    // The frame_done cycle still belongs to the finished frame, so start is not taken there.
                    if (start && !frame_done_q) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        x_q <= x_d;
                        y_q <= y_d;
                        s_q <= s_d;
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_xfer) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_scan_controller.sv
// Bench for ray_scan_controller with a small 4x3x2 frame; expected rays come from raster-order arithmetic.
module tb_ray_scan_controller;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int S  = 2;
    localparam int GL = 2;
    localparam int N  = H * V * S;

    logic       clk = 1'b0;
    logic       rst, start, abort, ray_ready;
    logic [9:0] pixel_x, pixel_y, tag_x, tag_y;
    logic [7:0] tag_sample;
    logic       gen_stall, ray_valid, tag_last, busy, frame_done;

    int checks = 0;
    int errors = 0;

    ray_scan_controller #(.H_RES(H), .V_RES(V), .SPP(S), .GEN_LATENCY(GL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ray_ready(ray_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .gen_stall(gen_stall), .ray_valid(ray_valid),
        .tag_x(tag_x), .tag_y(tag_y), .tag_sample(tag_sample), .tag_last(tag_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Sample k of the frame in raster order: {x, y, s, last}.
    function automatic logic [28:0] ref_tag(input int k);
        int x, y, s;
        s = k % S;
        x = (k / S) % H;
        y = k / (S * H);
        return {10'(x), 10'(y), 8'(s), (k == N - 1)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready low for cycles 8..12, 2: random ready.
    task automatic run_frame(input int mode, input bit poke);
        int ntx, done_cyc, first_vld, last_tx, pulses, idx;
        logic [28:0] exp_t;
        ntx = 0; done_cyc = -1; first_vld = -1; last_tx = -1; pulses = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (mode == 0)      ray_ready = 1'b1;
            else if (mode == 1) ray_ready = !(cyc >= 8 && cyc < 13);
            else                ray_ready = 1'($urandom_range(0, 1));
            start = poke && (cyc == 10 || cyc == 26 || cyc == 27);
            #2;
            if (cyc == 0) begin
                check("scan_entry_busy", busy, 1);
                check("scan_entry_pixel", {pixel_x, pixel_y}, 0);
            end
            if (mode == 1 && cyc >= 8 && cyc < 13)
                check("stall_gen_stall", gen_stall, 1);
            if (ray_valid) begin
                if (first_vld < 0) first_vld = cyc;
                exp_t = ref_tag(ntx);
                check("ray_tag", {tag_x, tag_y, tag_sample, tag_last}, exp_t);
                idx = ntx + GL;
                exp_t = (idx < N) ? ref_tag(idx) : '0;
                check("issue_pixel", {pixel_x, pixel_y}, exp_t[28:9]);
                if (ray_ready) begin
                    last_tx = cyc;
                    ntx++;
                end
            end
            if (frame_done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            tick();
        end
        start = 1'b0;
        ray_ready = 1'b1;
        check("transfer_count", ntx, N);
        check("frame_done_pulses", pulses, 1);
        check("done_after_last", done_cyc, last_tx + 2);
        check("idle_after_frame", {busy, ray_valid, frame_done}, 0);
        if (mode == 0) begin
            check("first_valid_cycle", first_vld, GL);
            check("frame_done_cycle", done_cyc, N + GL + 1);
        end
    endtask

    initial begin
        int quiet;
        logic [28:0] t10;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ray_ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {pixel_x, pixel_y, gen_stall, ray_valid, tag_x, tag_y, tag_sample, tag_last, busy, frame_done}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_no_start", {busy, ray_valid}, 0);

        // Full frame with ready high, start poked in SCAN and around DONE.
        begin_frame();
        run_frame(0, 1'b1);

        // Frame with a 5-cycle backpressure window.
        begin_frame();
        run_frame(1, 1'b0);

        // Frame with random backpressure.
        begin_frame();
        run_frame(2, 1'b0);

        // Abort on transfer 10.
        begin_frame();
        ray_ready = 1'b1;
        repeat (12) tick();
        t10 = ref_tag(10);
        check("abort_pre_tag", {ray_valid, tag_x, tag_y, tag_sample, tag_last}, {1'b1, t10});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abort_outputs", {busy, ray_valid, frame_done, pixel_x, pixel_y}, 0);
        quiet = 0;
        repeat (20) begin
            tick();
            quiet += int'(frame_done | ray_valid | busy);
        end
        check("abort_quiet", quiet, 0);
        begin_frame();
        run_frame(0, 1'b0);

        // Reset mid-DRAIN while stalled, with start in the same cycle.
        begin_frame();
        ray_ready = 1'b1;
        repeat (24) tick();
        ray_ready = 1'b0;
        #1;
        check("drain_stalled", {busy, ray_valid, gen_stall}, 3'b111);
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("rst_outputs",
              {pixel_x, pixel_y, gen_stall, ray_valid, tag_x, tag_y, tag_sample, tag_last, busy, frame_done}, 0);
        ray_ready = 1'b1;
        quiet = 0;
        repeat (6) begin
            tick();
            quiet += int'(busy | ray_valid | frame_done);
        end
        check("rst_start_ignored", quiet, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
